// File: rtl/pcie_h2d_buffer_scheduler_if.sv
// Signal bundle between the PCIe ingress/egress paths, the buffer consumer and the
// host-to-device buffer scheduler. The master modport is the scheduler side.
interface pcie_h2d_buffer_scheduler_if;
  logic        i_cmd_rst_stb;
  logic        i_cmd_wr_stb;
  logic [31:0] i_cmd_data_count;
  logic [31:0] i_buffer_size;
  logic [31:0] i_read_a_addr;
  logic [31:0] i_read_b_addr;
  logic        i_update_buf_stb;
  logic [1:0]  i_update_buf;
  logic        o_mrd_req;
  logic [31:0] o_mrd_addr;
  logic [9:0]  o_mrd_dword_cnt;
  logic        i_mrd_ack;
  logic        i_cmplt_dword_stb;
  logic        o_buf_valid;
  logic        o_buf_sel;
  logic [31:0] o_buf_dword_cnt;
  logic        i_buf_consumed_stb;
  logic        o_host_buf_done_stb;
  logic        o_host_buf_done_sel;
  logic        o_done_stb;
  logic        o_cfg_err;
  logic        o_timeout_err;
  logic        o_busy;
  logic [2:0]  o_state;

  modport master (
    input  i_cmd_rst_stb, i_cmd_wr_stb, i_cmd_data_count, i_buffer_size,
           i_read_a_addr, i_read_b_addr, i_update_buf_stb, i_update_buf,
           i_mrd_ack, i_cmplt_dword_stb, i_buf_consumed_stb,
    output o_mrd_req, o_mrd_addr, o_mrd_dword_cnt, o_buf_valid, o_buf_sel,
           o_buf_dword_cnt, o_host_buf_done_stb, o_host_buf_done_sel,
           o_done_stb, o_cfg_err, o_timeout_err, o_busy, o_state
  );

  modport slave (
    output i_cmd_rst_stb, i_cmd_wr_stb, i_cmd_data_count, i_buffer_size,
           i_read_a_addr, i_read_b_addr, i_update_buf_stb, i_update_buf,
           i_mrd_ack, i_cmplt_dword_stb, i_buf_consumed_stb,
    input  o_mrd_req, o_mrd_addr, o_mrd_dword_cnt, o_buf_valid, o_buf_sel,
           o_buf_dword_cnt, o_host_buf_done_stb, o_host_buf_done_sel,
           o_done_stb, o_cfg_err, o_timeout_err, o_busy, o_state
  );
endinterface

// File: rtl/pcie_h2d_buffer_scheduler.sv
// Ping-pong host buffer scheduler: splits a transfer into memory-read requests per
// host buffer, counts completion dwords, presents each filled buffer and releases it.
module pcie_h2d_buffer_scheduler #(
  parameter int unsigned MAX_RD_DWORDS  = 128,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                          clk,
  input logic                          rst,
  pcie_h2d_buffer_scheduler_if.master  bus
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BUF   = 3'd1,
    REQ        = 3'd2,
    WAIT_CMPLT = 3'd3,
    PRESENT    = 3'd4
  } state_e;

  localparam logic [9:0]  MAX_LEN  = 10'(MAX_RD_DWORDS);
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  rdy_q, rdy_d, rdy_set, rdy_clr;
  logic        sel_q, sel_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] bsize_q, bsize_d;
  logic [31:0] chunk_q, chunk_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] chunk_left;
  logic [9:0]  req_len_q, req_len_d;
  logic [9:0]  rcv_q, rcv_d;
  logic [15:0] tmr_q, tmr_d;

  logic        mrd_req_q, mrd_req_d;
  logic [31:0] mrd_addr_q, mrd_addr_d;
  logic [9:0]  mrd_cnt_q, mrd_cnt_d;
  logic        buf_valid_q, buf_valid_d;
  logic        buf_sel_q, buf_sel_d;
  logic [31:0] buf_cnt_q, buf_cnt_d;
  logic        host_done_stb_q, host_done_stb_d;
  logic        host_done_sel_q, host_done_sel_d;
  logic        done_stb_q, done_stb_d;
  logic        cfg_err_q, cfg_err_d;
  logic        tmo_err_q, tmo_err_d;
  logic        busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d         = state_q;
    rdy_d           = rdy_q;
    sel_d           = sel_q;
    remaining_d     = remaining_q;
    bsize_d         = bsize_q;
    chunk_d         = chunk_q;
    offset_d        = offset_q;
    req_len_d       = req_len_q;
    rcv_d           = rcv_q;
    tmr_d           = tmr_q;
    host_done_stb_d = 1'b0;
    host_done_sel_d = host_done_sel_q;
    done_stb_d      = 1'b0;
    cfg_err_d       = cfg_err_q;
    tmo_err_d       = tmo_err_q;
    rdy_set         = bus.i_update_buf_stb ? bus.i_update_buf : 2'b00;
    rdy_clr         = 2'b00;

    if (bus.i_cmd_rst_stb) begin
      state_d     = IDLE;
      rdy_d       = 2'b00;
      remaining_d = '0;
      cfg_err_d   = 1'b0;
      tmo_err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.i_cmd_wr_stb) begin
          if (bus.i_buffer_size == '0) begin
            cfg_err_d = 1'b1;
          end else if (bus.i_cmd_data_count == '0) begin
            done_stb_d = 1'b1;
          end else begin
            remaining_d = bus.i_cmd_data_count;
            bsize_d     = bus.i_buffer_size;
            sel_d       = 1'b0;
            state_d     = WAIT_BUF;
          end
        end
        WAIT_BUF: if (rdy_q[sel_q]) begin
          chunk_d  = (remaining_q < bsize_q) ? remaining_q : bsize_q;
          offset_d = '0;
          state_d  = REQ;
        end
        REQ: if (bus.i_mrd_ack) begin
          // The registered request length is exactly what egress accepted.
          req_len_d = mrd_cnt_q;
          rcv_d     = '0;
          tmr_d     = TMO_LOAD;
          state_d   = WAIT_CMPLT;
        end
        WAIT_CMPLT: begin
          if (bus.i_cmplt_dword_stb) begin
            rcv_d = rcv_q + 10'd1;
            tmr_d = TMO_LOAD;
            if (rcv_q + 10'd1 == req_len_q) begin
              offset_d = offset_q + 32'(req_len_q);
              state_d  = (offset_d == chunk_q) ? PRESENT : REQ;
            end
          end else if (tmr_q <= 16'd1) begin
            tmo_err_d = 1'b1;
            rdy_clr   = 2'b11;
            state_d   = IDLE;
          end else begin
            tmr_d = tmr_q - 16'd1;
          end
        end
        PRESENT: if (bus.i_buf_consumed_stb) begin
          rdy_clr[sel_q]  = 1'b1;
          host_done_stb_d = 1'b1;
          host_done_sel_d = sel_q;
          remaining_d     = remaining_q - chunk_q;
          sel_d           = ~sel_q;
          state_d         = (remaining_d == '0) ? IDLE : WAIT_BUF;
          done_stb_d      = (remaining_d == '0);
        end
        default: state_d = IDLE;
      endcase
      // A ready strobe landing on the bit being released keeps it set.
      rdy_d = (rdy_q & ~rdy_clr) | rdy_set;
    end

    chunk_left  = chunk_d - offset_d;
    mrd_req_d   = (state_d == REQ);
    mrd_addr_d  = mrd_req_d ? ((sel_d ? bus.i_read_b_addr : bus.i_read_a_addr) + (offset_d << 2)) : '0;
    mrd_cnt_d   = !mrd_req_d ? '0 : (chunk_left > 32'(MAX_LEN)) ? MAX_LEN : chunk_left[9:0];
    buf_valid_d = (state_d == PRESENT);
    buf_sel_d   = sel_d;
    buf_cnt_d   = buf_valid_d ? chunk_d : '0;
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      rdy_q           <= '0;
      sel_q           <= 1'b0;
      remaining_q     <= '0;
      bsize_q         <= '0;
      chunk_q         <= '0;
      offset_q        <= '0;
      req_len_q       <= '0;
      rcv_q           <= '0;
      tmr_q           <= '0;
      mrd_req_q       <= 1'b0;
      mrd_addr_q      <= '0;
      mrd_cnt_q       <= '0;
      buf_valid_q     <= 1'b0;
      buf_sel_q       <= 1'b0;
      buf_cnt_q       <= '0;
      host_done_stb_q <= 1'b0;
      host_done_sel_q <= 1'b0;
      done_stb_q      <= 1'b0;
      cfg_err_q       <= 1'b0;
      tmo_err_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rdy_q           <= rdy_d;
      sel_q           <= sel_d;
      remaining_q     <= remaining_d;
      bsize_q         <= bsize_d;
      chunk_q         <= chunk_d;
      offset_q        <= offset_d;
      req_len_q       <= req_len_d;
      rcv_q           <= rcv_d;
      tmr_q           <= tmr_d;
      mrd_req_q       <= mrd_req_d;
      mrd_addr_q      <= mrd_addr_d;
      mrd_cnt_q       <= mrd_cnt_d;
      buf_valid_q     <= buf_valid_d;
      buf_sel_q       <= buf_sel_d;
      buf_cnt_q       <= buf_cnt_d;
      host_done_stb_q <= host_done_stb_d;
      host_done_sel_q <= host_done_sel_d;
      done_stb_q      <= done_stb_d;
      cfg_err_q       <= cfg_err_d;
      tmo_err_q       <= tmo_err_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.o_mrd_req           = mrd_req_q;
  assign bus.o_mrd_addr          = mrd_addr_q;
  assign bus.o_mrd_dword_cnt     = mrd_cnt_q;
  assign bus.o_buf_valid         = buf_valid_q;
  assign bus.o_buf_sel           = buf_sel_q;
  assign bus.o_buf_dword_cnt     = buf_cnt_q;
  assign bus.o_host_buf_done_stb = host_done_stb_q;
  assign bus.o_host_buf_done_sel = host_done_sel_q;
  assign bus.o_done_stb          = done_stb_q;
  assign bus.o_cfg_err           = cfg_err_q;
  assign bus.o_timeout_err       = tmo_err_q;
  assign bus.o_busy              = busy_q;
  assign bus.o_state             = state_q;
endmodule

// File: tb/tb_pcie_h2d_buffer_scheduler.sv
// Directed bench for pcie_h2d_buffer_scheduler: single/multi-chunk transfers,
// buffer stalls, timeout, command reset and configuration boundary cases.
module tb_pcie_h2d_buffer_scheduler;
  localparam logic [31:0] A_BASE = 32'h0000_1000;
  localparam logic [31:0] B_BASE = 32'h0000_8000;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   req_cnt  = 0;
  logic req_prev = 1'b0;

  pcie_h2d_buffer_scheduler_if bus ();

  pcie_h2d_buffer_scheduler #(
    .MAX_RD_DWORDS  (128),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.o_done_stb) done_cnt++;
    if (bus.o_mrd_req && !req_prev) req_cnt++;
    req_prev = bus.o_mrd_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wr(input logic [31:0] count, input logic [31:0] size);
    bus.i_cmd_wr_stb     = 1'b1;
    bus.i_cmd_data_count = count;
    bus.i_buffer_size    = size;
    step();
    bus.i_cmd_wr_stb     = 1'b0;
  endtask

  task automatic set_ready(input logic [1:0] bits);
    bus.i_update_buf_stb = 1'b1;
    bus.i_update_buf     = bits;
    step();
    bus.i_update_buf_stb = 1'b0;
    bus.i_update_buf     = 2'b00;
  endtask

  task automatic cmd_rst();
    bus.i_cmd_rst_stb = 1'b1;
    step();
    bus.i_cmd_rst_stb = 1'b0;
  endtask

  task automatic send_cmplt(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_cmplt_dword_stb = 1'b1;
      step();
    end
    bus.i_cmplt_dword_stb = 1'b0;
  endtask

  // Waits (bounded) for a request, checks it, acknowledges it.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] cnt);
    int n = 0;
    while (!bus.o_mrd_req && n < 50) begin
      step();
      n++;
    end
    check("mrd_req_seen", 32'(bus.o_mrd_req), 32'd1);
    check("mrd_addr", bus.o_mrd_addr, addr);
    check("mrd_cnt", 32'(bus.o_mrd_dword_cnt), cnt);
    bus.i_mrd_ack = 1'b1;
    step();
    bus.i_mrd_ack = 1'b0;
    check("mrd_req_drop", 32'(bus.o_mrd_req), 32'd0);
    check("state_wait_cmplt", 32'(bus.o_state), 32'd3);
  endtask

  // Called right after the final completion strobe: presents, consumes, checks pulses.
  task automatic do_present(input logic [31:0] cnt, input logic sel, input logic last);
    check("buf_valid", 32'(bus.o_buf_valid), 32'd1);
    check("buf_cnt", bus.o_buf_dword_cnt, cnt);
    check("buf_sel", 32'(bus.o_buf_sel), 32'(sel));
    bus.i_buf_consumed_stb = 1'b1;
    step();
    bus.i_buf_consumed_stb = 1'b0;
    check("buf_valid_drop", 32'(bus.o_buf_valid), 32'd0);
    check("host_done_stb", 32'(bus.o_host_buf_done_stb), 32'd1);
    check("host_done_sel", 32'(bus.o_host_buf_done_sel), 32'(sel));
    check("done_stb", 32'(bus.o_done_stb), 32'(last));
    step();
    check("host_done_pulse", 32'(bus.o_host_buf_done_stb), 32'd0);
    check("done_pulse", 32'(bus.o_done_stb), 32'd0);
  endtask

  initial begin
    int d0;
    int r0;
    rst                    = 1'b1;
    bus.i_cmd_rst_stb      = 1'b0;
    bus.i_cmd_wr_stb       = 1'b0;
    bus.i_cmd_data_count   = '0;
    bus.i_buffer_size      = '0;
    bus.i_read_a_addr      = A_BASE;
    bus.i_read_b_addr      = B_BASE;
    bus.i_update_buf_stb   = 1'b0;
    bus.i_update_buf       = 2'b00;
    bus.i_mrd_ack          = 1'b0;
    bus.i_cmplt_dword_stb  = 1'b0;
    bus.i_buf_consumed_stb = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_state", 32'(bus.o_state), 32'd0);
    check("rst_mrd_req", 32'(bus.o_mrd_req), 32'd0);
    check("rst_buf_valid", 32'(bus.o_buf_valid), 32'd0);
    check("rst_errs", {30'd0, bus.o_cfg_err, bus.o_timeout_err}, 32'd0);
    rst = 1'b0;
    step();

    // Single buffer: 64 dwords into a 256-dword buffer A.
    set_ready(2'b01);
    pulse_wr(32'd64, 32'd256);
    check("t1_wait_buf", 32'(bus.o_state), 32'd1);
    check("t1_busy", 32'(bus.o_busy), 32'd1);
    step();
    check("t1_req_n2", 32'(bus.o_mrd_req), 32'd1);
    do_req(A_BASE, 32'd64);
    send_cmplt(64);
    do_present(32'd64, 1'b0, 1'b1);
    check("t1_idle", 32'(bus.o_state), 32'd0);

    // 300 dwords, 256-dword buffers, 128-dword requests, both buffers ready.
    set_ready(2'b11);
    pulse_wr(32'd300, 32'd256);
    do_req(A_BASE, 32'd128);
    send_cmplt(128);
    do_req(A_BASE + 32'h200, 32'd128);
    send_cmplt(128);
    do_present(32'd256, 1'b0, 1'b0);
    do_req(B_BASE, 32'd44);
    send_cmplt(44);
    do_present(32'd44, 1'b1, 1'b1);

    // Same transfer with B not ready: stall in WAIT_BUF until B is marked ready.
    set_ready(2'b01);
    pulse_wr(32'd300, 32'd256);
    do_req(A_BASE, 32'd128);
    send_cmplt(128);
    do_req(A_BASE + 32'h200, 32'd128);
    send_cmplt(128);
    do_present(32'd256, 1'b0, 1'b0);
    r0 = req_cnt;
    repeat (5) step();
    check("t3_stall_state", 32'(bus.o_state), 32'd1);
    check("t3_stall_noreq", 32'(req_cnt - r0), 32'd0);
    set_ready(2'b10);
    step();
    check("t3_resume_req", 32'(bus.o_mrd_req), 32'd1);
    do_req(B_BASE, 32'd44);
    send_cmplt(44);
    do_present(32'd44, 1'b1, 1'b1);

    // Zero-length command completes immediately without a request.
    r0 = req_cnt;
    pulse_wr(32'd0, 32'd256);
    check("zero_done", 32'(bus.o_done_stb), 32'd1);
    check("zero_state", 32'(bus.o_state), 32'd0);
    step();
    check("zero_done_pulse", 32'(bus.o_done_stb), 32'd0);
    check("zero_noreq", 32'(req_cnt - r0), 32'd0);

    // Zero buffer size flags a configuration error.
    pulse_wr(32'd10, 32'd0);
    check("cfg_err", 32'(bus.o_cfg_err), 32'd1);
    check("cfg_state", 32'(bus.o_state), 32'd0);

    // Completions stop after 10 of 128: timeout after exactly 20 idle cycles.
    set_ready(2'b01);
    pulse_wr(32'd128, 32'd256);
    do_req(A_BASE, 32'd128);
    send_cmplt(10);
    d0 = done_cnt;
    repeat (19) step();
    check("tmo_early", 32'(bus.o_timeout_err), 32'd0);
    step();
    check("tmo_err", 32'(bus.o_timeout_err), 32'd1);
    check("tmo_state", 32'(bus.o_state), 32'd0);
    check("tmo_nodone", 32'(done_cnt - d0), 32'd0);

    // Command reset mid-completion clears errors and ready flags; late completions are ignored.
    set_ready(2'b01);
    pulse_wr(32'd64, 32'd256);
    do_req(A_BASE, 32'd64);
    send_cmplt(5);
    cmd_rst();
    check("crst_state", 32'(bus.o_state), 32'd0);
    check("crst_busy", 32'(bus.o_busy), 32'd0);
    check("crst_errs", {30'd0, bus.o_cfg_err, bus.o_timeout_err}, 32'd0);
    r0 = req_cnt;
    d0 = done_cnt;
    send_cmplt(10);
    check("crst_late_state", 32'(bus.o_state), 32'd0);
    check("crst_late_valid", 32'(bus.o_buf_valid), 32'd0);
    check("crst_late_quiet", 32'(req_cnt - r0 + done_cnt - d0), 32'd0);
    pulse_wr(32'd16, 32'd256);
    repeat (3) step();
    check("crst_rdy_clear", 32'(bus.o_state), 32'd1);
    check("crst_rdy_noreq", 32'(bus.o_mrd_req), 32'd0);
    cmd_rst();
    check("crst2_state", 32'(bus.o_state), 32'd0);

    // Ready set in the same cycle consume clears it: set wins.
    set_ready(2'b01);
    pulse_wr(32'd16, 32'd256);
    do_req(A_BASE, 32'd16);
    send_cmplt(16);
    check("sw_valid", 32'(bus.o_buf_valid), 32'd1);
    bus.i_buf_consumed_stb = 1'b1;
    bus.i_update_buf_stb   = 1'b1;
    bus.i_update_buf       = 2'b01;
    step();
    bus.i_buf_consumed_stb = 1'b0;
    bus.i_update_buf_stb   = 1'b0;
    bus.i_update_buf       = 2'b00;
    check("sw_done", 32'(bus.o_done_stb), 32'd1);
    pulse_wr(32'd16, 32'd256);
    check("sw_wait_buf", 32'(bus.o_state), 32'd1);
    step();
    check("sw_req", 32'(bus.o_mrd_req), 32'd1);
    do_req(A_BASE, 32'd16);
    send_cmplt(16);
    do_present(32'd16, 1'b0, 1'b1);

    // Asynchronous reset mid-transfer forces reset values at once.
    set_ready(2'b01);
    pulse_wr(32'd64, 32'd256);
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_req", 32'(bus.o_mrd_req), 32'd0);
    check("arst_state", 32'(bus.o_state), 32'd0);
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
